d_cache: RTL and testbench

//  Blocking, direct-mapped, write-through, no-write-allocate data cache, one word per line.

---
 rtl/d_cache_pkg.sv | 43 ++++
 rtl/d_cache_if.sv | 21 ++
 rtl/d_cache_array.sv | 53 +++++
 rtl/d_cache.sv | 105 ++++++++++
 tb/tb_d_cache.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/d_cache_pkg.sv
// Shared types and constants for the direct-mapped write-through data cache.
// Holds the FSM state encoding, the segment decode values and the bus size codes.
package d_cache_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRdAddr,
    StRdData,
    StWrAddr,
    StWrData,
    StDone
  } state_e;

  localparam logic [1:0] KsegHi      = 2'b10;
  localparam logic [2:0] UncachedSeg = 3'b101;

  localparam logic [1:0] SizeByte = 2'd0;
  localparam logic [1:0] SizeHalf = 2'd1;
  localparam logic [1:0] SizeWord = 2'd2;

  function automatic logic [1:0] wenToSize(input logic [3:0] wen);
    logic [1:0] size;
    size = SizeWord;
    case (wen)
      4'b0011, 4'b1100:                   size = SizeHalf;
      4'b0001, 4'b0010, 4'b0100, 4'b1000: size = SizeByte;
      default:                            size = SizeWord;
    endcase
    return size;
  endfunction

  // Byte offset of the lowest enabled lane.
  function automatic logic [1:0] wenToOffset(input logic [3:0] wen);
    logic [1:0] offset;
    offset = 2'd0;
    if (wen[0])      offset = 2'd0;
    else if (wen[1]) offset = 2'd1;
    else if (wen[2]) offset = 2'd2;
    else if (wen[3]) offset = 2'd3;
    return offset;
  endfunction

endpackage

// File: rtl/d_cache_if.sv
// SRAM-like data bus between the data cache (master) and the AXI bridge (slave).
interface d_cache_if;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

// File: rtl/d_cache_array.sv
// Valid/tag/data storage for the data cache, one word per line.
// Combinational read; line fill or byte-merge write; valid bits cleared by reset.
module d_cache_array #(
  parameter int unsigned INDEX_WIDTH = 7
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [INDEX_WIDTH-1:0] index_i,
  output logic                   valid_o,
  output logic [29-INDEX_WIDTH:0] tag_o,
  output logic [31:0]            data_o,
  input  logic                   fillEn_i,
  input  logic [29-INDEX_WIDTH:0] fillTag_i,
  input  logic [31:0]            fillData_i,
  input  logic                   mergeEn_i,
  input  logic [3:0]             mergeWen_i,
  input  logic [31:0]            mergeData_i
);

  localparam int unsigned Lines    = 1 << INDEX_WIDTH;
  localparam int unsigned TagWidth = 30 - INDEX_WIDTH;

  logic [Lines-1:0]    valid_q;
  logic [TagWidth-1:0] tag_q  [Lines];
  logic [31:0]         data_q [Lines];

  always_comb begin
    valid_o = valid_q[index_i];
    tag_o   = tag_q[index_i];
    data_o  = data_q[index_i];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (fillEn_i) begin
      valid_q[index_i] <= 1'b1;
    end
  end

  // Tag/data need no reset: a line is only trusted when its valid bit is set.
  always_ff @(posedge clk) begin
    if (fillEn_i) begin
      tag_q[index_i]  <= fillTag_i;
      data_q[index_i] <= fillData_i;
    end else if (mergeEn_i) begin
      for (int b = 0; b < 4; b++) begin
        if (mergeWen_i[b]) data_q[index_i][8*b +: 8] <= mergeData_i[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/d_cache.sv
// Blocking direct-mapped write-through, no-write-allocate data cache.
// Stalls the pipeline on read misses, uncached accesses and every store.
module d_cache
  import d_cache_pkg::*;
#(
  parameter int unsigned INDEX_WIDTH = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_enM,
  input  logic [31:0] mem_addrM,
  input  logic [3:0]  mem_wenM,
  input  logic [31:0] mem_wdataM,
  input  logic        flush_exceptionM,
  input  logic        stallM,
  output logic [31:0] mem_rdataM,
  output logic        d_cache_stall,
  d_cache_if.master   bus
);

  localparam int unsigned TagWidth = 30 - INDEX_WIDTH;

  state_e                 state_q;
  logic [31:0]            savedData_q;
  logic [29:0]            pword;
  logic [INDEX_WIDTH-1:0] index;
  logic [TagWidth-1:0]    tag;
  logic                   uncached, isWrite, active, tagHit, readHit;
  logic                   lineValid;
  logic [TagWidth-1:0]    lineTag;
  logic [31:0]            lineData;
  logic                   fillEn, mergeEn;
  logic                   unusedAddrBits;

  // Word-granular physical address; the byte offset comes from the strobes.
  always_comb begin
    pword    = (mem_addrM[31:30] == KsegHi) ? {3'b000, mem_addrM[28:2]} : mem_addrM[31:2];
    index    = pword[INDEX_WIDTH-1:0];
    tag      = pword[29:INDEX_WIDTH];
    uncached = (mem_addrM[31:29] == UncachedSeg);
    isWrite  = |mem_wenM;
    active   = mem_enM & ~flush_exceptionM;
    tagHit   = lineValid & (lineTag == tag);
    readHit  = active & ~isWrite & ~uncached & tagHit;
  end

  assign unusedAddrBits = ^mem_addrM[1:0];

  d_cache_array #(
    .INDEX_WIDTH(INDEX_WIDTH)
  ) u_array (
    .clk        (clk),
    .rst        (rst),
    .index_i    (index),
    .valid_o    (lineValid),
    .tag_o      (lineTag),
    .data_o     (lineData),
    .fillEn_i   (fillEn),
    .fillTag_i  (tag),
    .fillData_i (bus.data_rdata),
    .mergeEn_i  (mergeEn),
    .mergeWen_i (mem_wenM),
    .mergeData_i(mem_wdataM)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      savedData_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (active && !readHit) state_q <= isWrite ? StWrAddr : StRdAddr;
        end
        StRdAddr: if (bus.data_addr_ok) state_q <= StRdData;
        StWrAddr: if (bus.data_addr_ok) state_q <= StWrData;
        StRdData: begin
          if (bus.data_data_ok) begin
            savedData_q <= bus.data_rdata;
            state_q     <= StDone;
          end
        end
        StWrData: if (bus.data_data_ok) state_q <= StDone;
        StDone:   if (!stallM) state_q <= StIdle;
        default:  state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    fillEn  = (state_q == StRdData) & bus.data_data_ok & ~uncached;
    // Write-through without allocation: only an already-resident line is updated.
    mergeEn = (state_q == StWrData) & bus.data_data_ok & ~uncached & tagHit;

    d_cache_stall = (state_q == StIdle) ? (active & ~readHit) : (state_q != StDone);
    mem_rdataM    = ((state_q == StIdle) && readHit) ? lineData : savedData_q;

    bus.data_req   = (state_q == StRdAddr) || (state_q == StWrAddr);
    bus.data_wr    = isWrite;
    bus.data_size  = isWrite ? wenToSize(mem_wenM) : SizeWord;
    bus.data_addr  = {pword, (isWrite ? wenToOffset(mem_wenM) : 2'b00)};
    bus.data_wdata = mem_wdataM;
  end

endmodule

// File: tb/tb_d_cache.sv
// Directed self-checking bench for d_cache with a zero-wait SRAM-like bus model.
module tb_d_cache;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_enM = 1'b0;
  logic [31:0] mem_addrM = '0;
  logic [3:0]  mem_wenM = '0;
  logic [31:0] mem_wdataM = '0;
  logic        flush_exceptionM = 1'b0;
  logic        stallM = 1'b0;
  logic [31:0] mem_rdataM;
  logic        d_cache_stall;

  int nCompared = 0;
  int nMismatched = 0;

  d_cache_if bus ();

  d_cache #(
    .INDEX_WIDTH(7)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .mem_enM         (mem_enM),
    .mem_addrM       (mem_addrM),
    .mem_wenM        (mem_wenM),
    .mem_wdataM      (mem_wdataM),
    .flush_exceptionM(flush_exceptionM),
    .stallM          (stallM),
    .mem_rdataM      (mem_rdataM),
    .d_cache_stall   (d_cache_stall),
    .bus             (bus)
  );

  always #5 clk = ~clk;

  // Bus model: addr_ok in the request cycle, data_ok the following cycle.
  logic [31:0] memory [1024];
  logic        pending = 1'b0;
  logic        memInitDone = 1'b0;
  logic [31:0] rdAddr = '0;
  logic [31:0] lastAddr = '0;
  logic [1:0]  lastSize = '0;
  logic        lastWr = 1'b0;
  int          busReads = 0;
  int          busWrites = 0;

  assign bus.data_addr_ok = bus.data_req;
  assign bus.data_data_ok = pending;
  assign bus.data_rdata   = memory[rdAddr[11:2]];

  always @(posedge clk) begin
    if (rst) begin
      pending <= 1'b0;
      if (!memInitDone) begin
        for (int i = 0; i < 1024; i++) memory[i] <= '0;
        memInitDone <= 1'b1;
      end
    end else begin
      pending <= 1'b0;
      if (bus.data_req && bus.data_addr_ok) begin
        pending  <= 1'b1;
        rdAddr   <= bus.data_addr;
        lastAddr <= bus.data_addr;
        lastSize <= bus.data_size;
        lastWr   <= bus.data_wr;
        if (bus.data_wr) begin
          busWrites <= busWrites + 1;
          case (bus.data_size)
            2'd2: memory[bus.data_addr[11:2]] <= bus.data_wdata;
            2'd1: begin
              if (bus.data_addr[1]) memory[bus.data_addr[11:2]][31:16] <= bus.data_wdata[31:16];
              else                  memory[bus.data_addr[11:2]][15:0]  <= bus.data_wdata[15:0];
            end
            default: memory[bus.data_addr[11:2]][8*bus.data_addr[1:0] +: 8] <=
                       bus.data_wdata[8*bus.data_addr[1:0] +: 8];
          endcase
        end else begin
          busReads <= busReads + 1;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1);
  end

  // One CPU access; counts stall cycles and returns the data seen when the stall drops.
  task automatic access(input logic [31:0] addr, input logic [3:0] wen, input logic [31:0] wdata,
                        output int stalls, output logic [31:0] rdata);
    @(negedge clk);
    mem_enM = 1'b1; mem_addrM = addr; mem_wenM = wen; mem_wdataM = wdata;
    #1;
    stalls = 0;
    while (d_cache_stall && stalls < 20) begin
      @(posedge clk); @(negedge clk); #1;
      stalls++;
    end
    rdata = mem_rdataM;
    @(posedge clk); #1;
    mem_enM = 1'b0; mem_wenM = '0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0; #1;
    nCompared++; if (d_cache_stall !== 1'b0) begin nMismatched++; $display("FAIL reset_stall: got %b want 0", d_cache_stall); end
    nCompared++; if (bus.data_req !== 1'b0) begin nMismatched++; $display("FAIL reset_req: got %b want 0", bus.data_req); end
    nCompared++; if (mem_rdataM !== 32'h0) begin nMismatched++; $display("FAIL reset_rdata: got %h want 0", mem_rdataM); end
  endtask

  task automatic test_read_miss_hit;
    int s; logic [31:0] d; int r0;
    access(32'h8000_0040, 4'hF, 32'h1122_3344, s, d);
    nCompared++; if (s !== 3) begin nMismatched++; $display("FAIL sw_stall: got %0d want 3", s); end
    nCompared++; if (lastWr !== 1'b1 || lastSize !== 2'd2) begin nMismatched++; $display("FAIL sw_attr: got wr=%b size=%0d want wr=1 size=2", lastWr, lastSize); end
    access(32'h8000_0040, 4'h0, 32'h0, s, d);
    nCompared++; if (s !== 3) begin nMismatched++; $display("FAIL rd_cold_stall: got %0d want 3", s); end
    nCompared++; if (lastAddr !== 32'h0000_0040 || lastSize !== 2'd2 || lastWr !== 1'b0) begin nMismatched++; $display("FAIL rd_cold_bus: got addr=%h size=%0d wr=%b want 00000040/2/0", lastAddr, lastSize, lastWr); end
    nCompared++; if (d !== 32'h1122_3344) begin nMismatched++; $display("FAIL rd_cold_data: got %h want 11223344", d); end
    r0 = busReads;
    access(32'h8000_0040, 4'h0, 32'h0, s, d);
    nCompared++; if (s !== 0) begin nMismatched++; $display("FAIL rd_hit_stall: got %0d want 0", s); end
    nCompared++; if (d !== 32'h1122_3344) begin nMismatched++; $display("FAIL rd_hit_data: got %h want 11223344", d); end
    nCompared++; if (busReads !== r0) begin nMismatched++; $display("FAIL rd_hit_bus: got %0d reads want %0d", busReads, r0); end
  endtask

  task automatic test_partial_store;
    int s; logic [31:0] d;
    access(32'h8000_0041, 4'b0010, 32'h0000_AA00, s, d);
    nCompared++; if (s !== 3) begin nMismatched++; $display("FAIL sb_stall: got %0d want 3", s); end
    nCompared++; if (lastSize !== 2'd0 || lastAddr !== 32'h0000_0041) begin nMismatched++; $display("FAIL sb_bus: got size=%0d addr=%h want 0/00000041", lastSize, lastAddr); end
    access(32'h8000_0040, 4'h0, 32'h0, s, d);
    nCompared++; if (s !== 0 || d !== 32'h1122_AA44) begin nMismatched++; $display("FAIL sb_reread: got stall=%0d data=%h want 0/1122aa44", s, d); end
    access(32'h8000_0042, 4'b1100, 32'hBEEF_0000, s, d);
    nCompared++; if (lastSize !== 2'd1 || lastAddr !== 32'h0000_0042) begin nMismatched++; $display("FAIL sh_bus: got size=%0d addr=%h want 1/00000042", lastSize, lastAddr); end
    access(32'h8000_0040, 4'h0, 32'h0, s, d);
    nCompared++; if (s !== 0 || d !== 32'hBEEF_AA44) begin nMismatched++; $display("FAIL sh_reread: got stall=%0d data=%h want 0/beefaa44", s, d); end
  endtask

  task automatic test_uncached;
    int s; logic [31:0] d; int r0;
    r0 = busReads;
    for (int i = 0; i < 2; i++) begin
      access(32'hA000_0040, 4'h0, 32'h0, s, d);
      nCompared++; if (s !== 3 || d !== 32'hBEEF_AA44) begin nMismatched++; $display("FAIL unc_read%0d: got stall=%0d data=%h want 3/beefaa44", i, s, d); end
    end
    nCompared++; if (busReads - r0 !== 2) begin nMismatched++; $display("FAIL unc_bus_count: got %0d want 2", busReads - r0); end
    access(32'hA000_0080, 4'h0, 32'h0, s, d);
    access(32'h8000_0080, 4'h0, 32'h0, s, d);
    nCompared++; if (s !== 3) begin nMismatched++; $display("FAIL unc_no_fill: got stall=%0d want 3", s); end
    access(32'h8000_0040, 4'h0, 32'h0, s, d);
    nCompared++; if (s !== 0) begin nMismatched++; $display("FAIL unc_keeps_line: got stall=%0d want 0", s); end
  endtask

  task automatic test_conflict;
    int s; logic [31:0] d;
    access(32'h8000_0240, 4'hF, 32'hCAFE_F00D, s, d);
    access(32'h8000_0040, 4'h0, 32'h0, s, d);
    nCompared++; if (s !== 0 || d !== 32'hBEEF_AA44) begin nMismatched++; $display("FAIL wmiss_no_alloc: got stall=%0d data=%h want 0/beefaa44", s, d); end
    access(32'h8000_0240, 4'h0, 32'h0, s, d);
    nCompared++; if (s !== 3 || d !== 32'hCAFE_F00D) begin nMismatched++; $display("FAIL conflict_miss: got stall=%0d data=%h want 3/cafef00d", s, d); end
    access(32'h8000_0240, 4'h0, 32'h0, s, d);
    nCompared++; if (s !== 0) begin nMismatched++; $display("FAIL conflict_hit: got stall=%0d want 0", s); end
    access(32'h8000_0040, 4'h0, 32'h0, s, d);
    nCompared++; if (s !== 3 || d !== 32'hBEEF_AA44) begin nMismatched++; $display("FAIL conflict_evicted: got stall=%0d data=%h want 3/beefaa44", s, d); end
  endtask

  task automatic test_store_stall_m;
    int s; int w0;
    w0 = busWrites;
    @(negedge clk);
    mem_enM = 1'b1; mem_addrM = 32'h8000_0044; mem_wenM = 4'hF; mem_wdataM = 32'h5555_AAAA;
    #1;
    s = 0;
    while (d_cache_stall && s < 20) begin
      @(posedge clk); @(negedge clk); #1;
      s++;
    end
    nCompared++; if (s !== 3) begin nMismatched++; $display("FAIL stm_stall: got %0d want 3", s); end
    stallM = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); @(negedge clk); #1;
      nCompared++; if (d_cache_stall !== 1'b0 || bus.data_req !== 1'b0) begin nMismatched++; $display("FAIL stm_done%0d: got stall=%b req=%b want 0/0", i, d_cache_stall, bus.data_req); end
      nCompared++; if (mem_rdataM !== 32'hBEEF_AA44) begin nMismatched++; $display("FAIL stm_rdata%0d: got %h want beefaa44", i, mem_rdataM); end
    end
    stallM = 1'b0;
    @(posedge clk); #1;
    mem_enM = 1'b0; mem_wenM = '0;
    repeat (3) @(posedge clk);
    nCompared++; if (busWrites - w0 !== 1) begin nMismatched++; $display("FAIL stm_one_write: got %0d want 1", busWrites - w0); end
  endtask

  task automatic test_flush;
    int r0; int w0;
    r0 = busReads; w0 = busWrites;
    @(negedge clk);
    mem_enM = 1'b1; flush_exceptionM = 1'b1; mem_addrM = 32'h8000_0100; mem_wenM = 4'h0;
    for (int i = 0; i < 3; i++) begin
      #1;
      nCompared++; if (d_cache_stall !== 1'b0 || bus.data_req !== 1'b0) begin nMismatched++; $display("FAIL flush%0d: got stall=%b req=%b want 0/0", i, d_cache_stall, bus.data_req); end
      @(negedge clk);
    end
    mem_enM = 1'b0; flush_exceptionM = 1'b0;
    nCompared++; if (busReads !== r0 || busWrites !== w0) begin nMismatched++; $display("FAIL flush_bus: got %0d/%0d transactions want %0d/%0d", busReads, busWrites, r0, w0); end
  endtask

  task automatic test_reset_mid;
    int s; logic [31:0] d;
    access(32'h8000_0040, 4'h0, 32'h0, s, d);
    nCompared++; if (s !== 0) begin nMismatched++; $display("FAIL rstmid_prehit: got stall=%0d want 0", s); end
    @(negedge clk);
    mem_enM = 1'b1; mem_addrM = 32'h8000_0300; mem_wenM = 4'h0;
    @(posedge clk); @(negedge clk); #1;
    nCompared++; if (bus.data_req !== 1'b1) begin nMismatched++; $display("FAIL rstmid_req: got %b want 1", bus.data_req); end
    @(posedge clk); @(negedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; mem_enM = 1'b0;
    #1;
    nCompared++; if (bus.data_req !== 1'b0 || d_cache_stall !== 1'b0) begin nMismatched++; $display("FAIL rstmid_idle: got req=%b stall=%b want 0/0", bus.data_req, d_cache_stall); end
    access(32'h8000_0040, 4'h0, 32'h0, s, d);
    nCompared++; if (s !== 3 || d !== 32'hBEEF_AA44) begin nMismatched++; $display("FAIL rstmid_cleared: got stall=%0d data=%h want 3/beefaa44", s, d); end
  endtask

  initial begin
    test_reset();
    test_read_miss_hit();
    test_partial_store();
    test_uncached();
    test_conflict();
    test_store_stall_m();
    test_flush();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
